// File: rtl/global_dependency_manager.sv
// Admits one batch at a time and issues it once its read/write sets are clear of every in-flight slot.
// Offer to issue takes two cycles; the offer waits in CHECK on a conflict or a full table, and retires never stall.
module global_dependency_manager #(
    parameter int MAX_DEPENDENCIES     = 256,
    parameter int MAX_INFLIGHT_BATCHES = 4,
    parameter int SLOT_ID_WIDTH        = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        new_batch_valid,
    output logic                        new_batch_ready,
    input  logic [MAX_DEPENDENCIES-1:0] batch_read_deps_union,
    input  logic [MAX_DEPENDENCIES-1:0] batch_write_deps_union,
    input  logic [63:0]                 batch_owner_id,
    output logic                        m_issue_valid,
    input  logic                        m_issue_ready,
    output logic [SLOT_ID_WIDTH-1:0]    m_issue_slot,
    output logic [63:0]                 m_issue_owner_id,
    input  logic                        retire_valid,
    input  logic [SLOT_ID_WIDTH-1:0]    retire_slot,
    output logic [31:0]                 inflight_count,
    output logic [31:0]                 conflict_stall_cycles,
    output logic [31:0]                 batches_issued,
    output logic                        retire_error
);
    localparam int N = MAX_INFLIGHT_BATCHES;
    localparam int D = MAX_DEPENDENCIES;

    typedef enum logic [1:0] {IDLE, CHECK, ISSUE} state_t;

    state_t                   state_q, state_d;
    logic [N-1:0]             valid_q, valid_d;
    logic [D-1:0]             rd_q [N];
    logic [D-1:0]             wr_q [N];
    logic [63:0]              own_q [N];
    logic [D-1:0]             hold_rd_q, hold_wr_q;
    logic [63:0]              hold_own_q;
    logic [SLOT_ID_WIDTH-1:0] slot_q, slot_d;
    logic [31:0]              cnt_q, cnt_d;
    logic [31:0]              stall_q, stall_d;
    logic [31:0]              issued_q, issued_d;
    logic                     err_q, err_d;
    logic                     conflict, free_found, alloc, capture;
    logic [SLOT_ID_WIDTH-1:0] free_idx;

    always_comb begin
        conflict   = 1'b0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (valid_q[i] && ((|(hold_wr_q & (rd_q[i] | wr_q[i]))) || (|(hold_rd_q & wr_q[i]))))
                conflict = 1'b1;
        end
        // Walk downwards so the last hit is the lowest free index.
        for (int i = N - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = SLOT_ID_WIDTH'(i);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        slot_d   = slot_q;
        stall_d  = stall_q;
        issued_d = issued_q;
        err_d    = err_q;
        alloc    = 1'b0;
        capture  = 1'b0;
        cnt_d    = '0;

        case (state_q)
            IDLE: begin
                if (new_batch_valid) begin
                    capture = 1'b1;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                // Decision uses the table as it stood before any same-cycle retire.
                if (!conflict && free_found) begin
                    alloc   = 1'b1;
                    slot_d  = free_idx;
                    state_d = ISSUE;
                end else begin
                    stall_d = stall_q + 32'd1;
                end
            end
            ISSUE: begin
                if (m_issue_ready) begin
                    issued_d = issued_q + 32'd1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (retire_valid) begin
            if (valid_q[retire_slot]) valid_d[retire_slot] = 1'b0;
            else                      err_d = 1'b1;
        end
        if (alloc) valid_d[free_idx] = 1'b1;

        for (int i = 0; i < N; i++) cnt_d = cnt_d + 32'(valid_d[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            hold_rd_q  <= '0;
            hold_wr_q  <= '0;
            hold_own_q <= '0;
            slot_q     <= '0;
            cnt_q      <= '0;
            stall_q    <= '0;
            issued_q   <= '0;
            err_q      <= 1'b0;
            for (int i = 0; i < N; i++) begin
                rd_q[i]  <= '0;
                wr_q[i]  <= '0;
                own_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            slot_q   <= slot_d;
            cnt_q    <= cnt_d;
            stall_q  <= stall_d;
            issued_q <= issued_d;
            err_q    <= err_d;
            if (capture) begin
                hold_rd_q  <= batch_read_deps_union;
                hold_wr_q  <= batch_write_deps_union;
                hold_own_q <= batch_owner_id;
            end
            if (alloc) begin
                rd_q[free_idx]  <= hold_rd_q;
                wr_q[free_idx]  <= hold_wr_q;
                own_q[free_idx] <= hold_own_q;
            end
        end
    end

    // Owner is read back from the slot so it stays stable for the whole ISSUE phase.
    assign new_batch_ready       = (state_q == IDLE);
    assign m_issue_valid         = (state_q == ISSUE);
    assign m_issue_slot          = slot_q;
    assign m_issue_owner_id      = own_q[slot_q];
    assign inflight_count        = cnt_q;
    assign conflict_stall_cycles = stall_q;
    assign batches_issued        = issued_q;
    assign retire_error          = err_q;
endmodule

// File: tb/tb_global_dependency_manager.sv
// Directed bench for global_dependency_manager: issue, RAW conflict, full table, read-read, retire error, reset in ISSUE.
module tb_global_dependency_manager;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         new_batch_valid;
    logic         new_batch_ready;
    logic [255:0] rd, wr;
    logic [63:0]  owner;
    logic         m_issue_valid;
    logic         m_issue_ready;
    logic [1:0]   m_issue_slot;
    logic [63:0]  m_issue_owner_id;
    logic         retire_valid;
    logic [1:0]   retire_slot;
    logic [31:0]  inflight_count, conflict_stall_cycles, batches_issued;
    logic         retire_error;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    global_dependency_manager dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .new_batch_valid        (new_batch_valid),
        .new_batch_ready        (new_batch_ready),
        .batch_read_deps_union  (rd),
        .batch_write_deps_union (wr),
        .batch_owner_id         (owner),
        .m_issue_valid          (m_issue_valid),
        .m_issue_ready          (m_issue_ready),
        .m_issue_slot           (m_issue_slot),
        .m_issue_owner_id       (m_issue_owner_id),
        .retire_valid           (retire_valid),
        .retire_slot            (retire_slot),
        .inflight_count         (inflight_count),
        .conflict_stall_cycles  (conflict_stall_cycles),
        .batches_issued         (batches_issued),
        .retire_error           (retire_error)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bit_vec(input int b, output logic [255:0] v);
        v = '0;
        v[b] = 1'b1;
    endtask

    task automatic offer(input logic [255:0] r, input logic [255:0] w, input logic [63:0] o);
        rd = r;
        wr = w;
        owner = o;
        new_batch_valid = 1'b1;
        step();
        new_batch_valid = 1'b0;
    endtask

    // Conflict-free path: offer, CHECK, then ISSUE with the expected slot, then handshake back to IDLE.
    task automatic issue_one(input string tag, input logic [255:0] r, input logic [255:0] w,
                             input logic [63:0] o, input logic [1:0] exp_slot);
        offer(r, w, o);
        step();
        check({tag, "_vld"}, 64'(m_issue_valid), 64'd1);
        check({tag, "_slot"}, 64'(m_issue_slot), 64'(exp_slot));
        check({tag, "_own"}, m_issue_owner_id, o);
        step();
    endtask

    task automatic retire(input logic [1:0] s);
        retire_valid = 1'b1;
        retire_slot  = s;
        step();
        retire_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout tests=%0d", tests);
        $fatal(1, "timeout");
    end

    initial begin
        logic [255:0] v0, v1, v5, v7, z;
        z = '0;
        rst_n = 1'b0;
        new_batch_valid = 1'b0;
        rd = '0;
        wr = '0;
        owner = '0;
        m_issue_ready = 1'b1;
        retire_valid = 1'b0;
        retire_slot = '0;
        step();
        step();
        check("rst_ready", 64'(new_batch_ready), 64'd1);
        check("rst_ivld", 64'(m_issue_valid), 64'd0);
        check("rst_slot", 64'(m_issue_slot), 64'd0);
        check("rst_own", m_issue_owner_id, 64'd0);
        check("rst_infl", 64'(inflight_count), 64'd0);
        check("rst_err", 64'(retire_error), 64'd0);
        rst_n = 1'b1;
        step();

        // Batch A: R=bit0 W=bit1 owner 0x10
        bit_vec(0, v0);
        bit_vec(1, v1);
        offer(v0, v1, 64'h10);
        check("A_rdy_c1", 64'(new_batch_ready), 64'd0);
        check("A_ivld_c1", 64'(m_issue_valid), 64'd0);
        step();
        check("A_rdy_c2", 64'(new_batch_ready), 64'd0);
        check("A_ivld", 64'(m_issue_valid), 64'd1);
        check("A_slot", 64'(m_issue_slot), 64'd0);
        check("A_own", m_issue_owner_id, 64'h10);
        check("A_infl", 64'(inflight_count), 64'd1);
        step();
        check("A_issued", 64'(batches_issued), 64'd1);
        check("A_rdy_back", 64'(new_batch_ready), 64'd1);

        // Batch B: R=bit1 reads what A writes
        offer(v1, z, 64'h20);
        step();
        check("B_stall1", 64'(conflict_stall_cycles), 64'd1);
        check("B_blocked", 64'(m_issue_valid), 64'd0);
        step();
        check("B_stall2", 64'(conflict_stall_cycles), 64'd2);
        retire(2'd0);
        check("B_stall_preretire", 64'(conflict_stall_cycles), 64'd3);
        check("B_infl_retired", 64'(inflight_count), 64'd0);
        check("B_still_blocked", 64'(m_issue_valid), 64'd0);
        step();
        check("B_ivld", 64'(m_issue_valid), 64'd1);
        check("B_slot", 64'(m_issue_slot), 64'd0);
        check("B_own", m_issue_owner_id, 64'h20);
        check("B_stall_final", 64'(conflict_stall_cycles), 64'd3);
        step();
        check("B_issued", 64'(batches_issued), 64'd2);
        retire(2'd0);
        check("B_infl_clean", 64'(inflight_count), 64'd0);

        // Four disjoint writers fill the table
        for (int i = 0; i < 4; i++) begin
            logic [255:0] w;
            bit_vec(i, w);
            issue_one($sformatf("fill%0d", i), z, w, 64'(i + 1), 2'(i));
        end
        check("full_infl", 64'(inflight_count), 64'd4);
        check("full_issued", 64'(batches_issued), 64'd6);
        begin
            logic [255:0] w4;
            bit_vec(4, w4);
            offer(z, w4, 64'h55);
        end
        step();
        step();
        check("full_stall", 64'(conflict_stall_cycles), 64'd5);
        check("full_blocked", 64'(m_issue_valid), 64'd0);
        retire(2'd2);
        check("full_infl3", 64'(inflight_count), 64'd3);
        check("full_stall6", 64'(conflict_stall_cycles), 64'd6);
        step();
        check("fifth_ivld", 64'(m_issue_valid), 64'd1);
        check("fifth_slot", 64'(m_issue_slot), 64'd2);
        check("fifth_own", m_issue_owner_id, 64'h55);
        check("fifth_infl", 64'(inflight_count), 64'd4);
        step();
        check("fifth_issued", 64'(batches_issued), 64'd7);
        for (int i = 0; i < 4; i++) retire(2'(i));
        check("drain_infl", 64'(inflight_count), 64'd0);

        // Read-read sharing never conflicts
        bit_vec(5, v5);
        issue_one("rr0", v5, z, 64'h30, 2'd0);
        issue_one("rr1", v5, z, 64'h31, 2'd1);
        check("rr_stall", 64'(conflict_stall_cycles), 64'd6);
        check("rr_infl", 64'(inflight_count), 64'd2);
        check("rr_issued", 64'(batches_issued), 64'd9);

        // Retire of a free slot
        retire(2'd3);
        check("err_set", 64'(retire_error), 64'd1);
        check("err_infl", 64'(inflight_count), 64'd2);
        step();
        check("err_sticky", 64'(retire_error), 64'd1);

        // Executor backpressure, then reset while in ISSUE
        m_issue_ready = 1'b0;
        bit_vec(7, v7);
        offer(z, v7, 64'h77);
        step();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("hold_vld%0d", i), 64'(m_issue_valid), 64'd1);
            check($sformatf("hold_slot%0d", i), 64'(m_issue_slot), 64'd2);
            step();
        end
        check("hold_issued", 64'(batches_issued), 64'd9);
        rst_n = 1'b0;
        #1;
        check("rst2_ivld", 64'(m_issue_valid), 64'd0);
        check("rst2_infl", 64'(inflight_count), 64'd0);
        check("rst2_stall", 64'(conflict_stall_cycles), 64'd0);
        check("rst2_issued", 64'(batches_issued), 64'd0);
        check("rst2_err", 64'(retire_error), 64'd0);
        check("rst2_own", m_issue_owner_id, 64'd0);
        step();
        rst_n = 1'b1;
        m_issue_ready = 1'b1;
        step();
        check("rst2_ready", 64'(new_batch_ready), 64'd1);
        check("rst2_no_issue", 64'(batches_issued), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
